// File: rtl/klp32_pkg.sv
// klp32_pkg: shared decode types, opcodes and the control/immediate decode functions
package klp32_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] NOP = 32'h00000013;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_sel_e;
  typedef enum logic [3:0] {
    ALU_ADD = 4'h0, ALU_SLL = 4'h1, ALU_SLT = 4'h2, ALU_SLTU = 4'h3,
    ALU_XOR = 4'h4, ALU_SRL = 4'h5, ALU_OR = 4'h6, ALU_AND = 4'h7,
    ALU_SUB = 4'h8, ALU_SRA = 4'hD, ALU_PASS_B = 4'hF
  } alu_sel_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;
  typedef struct packed {
    logic [2:0] load_store_mode;
    logic       reg_wr_en;
    logic       alu_src_1_sel;
    logic       alu_src_2_sel;
    logic       br_u;
    logic       mem_rw;
    logic       pc_sel;
    imm_sel_e   imm_sel;
    alu_sel_e   alu_sel;
    wb_sel_e    wb_sel;
    logic       is_load;
    logic       illegal;
  } ctrl_t;
  function automatic logic uses_rs1(input logic [6:0] op);
    return op inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP};
  endfunction
  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {OP_BRANCH, OP_STORE, OP_OP};
  endfunction
  function automatic logic uses_rd(input logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP};
  endfunction
  // Raw 32-bit immediate; the caller sign-extends to the datapath width.
  function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_sel_e s);
    return s == IMM_I ? {{20{i[31]}}, i[31:20]} :
           s == IMM_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
           s == IMM_B ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
           s == IMM_U ? {i[31:12], 12'b0} :
           s == IMM_J ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} : '0;
  endfunction
  // Branch target arithmetic uses PC+imm in the ALU; comparison of rs1/rs2 happens in execute.
  function automatic ctrl_t decode_ctrl(input logic [31:0] inst, input logic rv32e);
    ctrl_t c;
    logic [6:0] op;
    logic [2:0] f3;
    logic alt, bad_reg, known;
    op = inst[6:0];
    f3 = inst[14:12];
    alt = inst[30] & (((op == OP_OP) & (f3 == 3'b000)) | ((op inside {OP_OP, OP_IMM}) & (f3 == 3'b101)));
    bad_reg = rv32e & ((uses_rs1(op) & inst[19]) | (uses_rs2(op) & inst[24]) | (uses_rd(op) & inst[11]));
    known = uses_rd(op) | (op inside {OP_BRANCH, OP_STORE, OP_FENCE, OP_SYSTEM});
    c = '0;
    c.load_store_mode = (op inside {OP_LOAD, OP_STORE}) ? f3 : 3'b000;
    c.reg_wr_en = uses_rd(op);
    c.alu_src_1_sel = op inside {OP_AUIPC, OP_JAL, OP_BRANCH};
    c.alu_src_2_sel = op != OP_OP;
    c.br_u = (op == OP_BRANCH) & f3[1];
    c.mem_rw = op == OP_STORE;
    c.pc_sel = op inside {OP_JAL, OP_JALR};
    c.imm_sel = (op inside {OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM}) ? IMM_I :
                op == OP_STORE ? IMM_S :
                op == OP_BRANCH ? IMM_B :
                (op inside {OP_LUI, OP_AUIPC}) ? IMM_U :
                op == OP_JAL ? IMM_J : IMM_NONE;
    c.alu_sel = op == OP_LUI ? ALU_PASS_B : (op inside {OP_OP, OP_IMM}) ? alu_sel_e'({alt, f3}) : ALU_ADD;
    c.wb_sel = op == OP_LOAD ? WB_MEM : c.pc_sel ? WB_PC4 : WB_ALU;
    c.is_load = op == OP_LOAD;
    c.illegal = !known | bad_reg;
    c.reg_wr_en = c.reg_wr_en & !c.illegal;
    c.mem_rw = c.mem_rw & !c.illegal;
    return c;
  endfunction
endpackage

// File: rtl/decode_pipe_if.sv
// decode_pipe_if: fetch-side, write-back and execute-side signals of the decode stage
interface decode_pipe_if import klp32_pkg::*; #(parameter int XLEN = 32);
  logic            i_valid;
  logic            o_ready;
  logic [31:0]     i_inst;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_pc_inc;
  logic            i_wb_en;
  logic [4:0]      i_wb_addr;
  logic [XLEN-1:0] i_wb_data;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [31:0]     o_decode_inst;
  logic [XLEN-1:0] o_decode_pc;
  logic [XLEN-1:0] o_decode_pc_inc;
  logic [XLEN-1:0] o_decode_data_1;
  logic [XLEN-1:0] o_decode_data_2;
  logic [XLEN-1:0] o_decode_immediate;
  logic [4:0]      o_decode_rd;
  ctrl_t           o_decode_ctrl;
  modport master (
    output i_valid, i_inst, i_pc, i_pc_inc, i_wb_en, i_wb_addr, i_wb_data, i_flush, i_ready,
    input  o_ready, o_valid, o_decode_inst, o_decode_pc, o_decode_pc_inc, o_decode_data_1,
           o_decode_data_2, o_decode_immediate, o_decode_rd, o_decode_ctrl
  );
  modport slave (
    input  i_valid, i_inst, i_pc, i_pc_inc, i_wb_en, i_wb_addr, i_wb_data, i_flush, i_ready,
    output o_ready, o_valid, o_decode_inst, o_decode_pc, o_decode_pc_inc, o_decode_data_1,
           o_decode_data_2, o_decode_immediate, o_decode_rd, o_decode_ctrl
  );
endinterface

// File: rtl/klp32_regfile.sv
// klp32_regfile: 2-read/1-write register file, x0 hard-wired to zero, optional write-back forwarding
module klp32_regfile #(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter int WB_BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);
  localparam int AW = $clog2(NUM_REGS);
  logic [XLEN-1:0] regs [NUM_REGS];
  logic we;
  assign we = wr_en & (wr_addr != 5'd0) & (int'(wr_addr) < NUM_REGS);
  function automatic logic [XLEN-1:0] rd(input logic [4:0] a);
    return a == 5'd0 ? '0 : (WB_BYPASS != 0 && we && wr_addr == a) ? wr_data : regs[a[AW-1:0]];
  endfunction
  assign rd1 = rd(rs1);
  assign rd2 = rd(rs2);
  // Register storage: cleared on reset, one write port.
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (we) regs[wr_addr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: RV32I/E decode stage with valid/ready output register, load-use stall and flush
module decode_pipe import klp32_pkg::*; #(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter int WB_BYPASS = 1
) (
  input logic         clk,
  input logic         reset,
  decode_pipe_if.slave bus
);
  ctrl_t ctrl;
  logic [XLEN-1:0] rd1, rd2, imm;
  logic [6:0] op;
  logic [4:0] rs1, rs2, hrs1, hrs2;
  logic free, hz, take, wb_hit;
  assign op = bus.i_inst[6:0];
  assign rs1 = bus.i_inst[19:15];
  assign rs2 = bus.i_inst[24:20];
  assign hrs1 = bus.o_decode_inst[19:15];
  assign hrs2 = bus.o_decode_inst[24:20];
  assign ctrl = decode_ctrl(bus.i_inst, NUM_REGS == 16);
  assign imm = XLEN'(signed'(imm_gen(bus.i_inst, ctrl.imm_sel)));
  assign free = !bus.o_valid | bus.i_ready;
  assign hz = bus.o_valid & bus.o_decode_ctrl.is_load & (bus.o_decode_rd != 5'd0) &
              ((uses_rs1(op) & (rs1 == bus.o_decode_rd)) | (uses_rs2(op) & (rs2 == bus.o_decode_rd)));
  assign bus.o_ready = free & !hz & !bus.i_flush;
  assign take = bus.i_valid & bus.o_ready;
  assign wb_hit = bus.i_wb_en & (bus.i_wb_addr != 5'd0);
  klp32_regfile #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .WB_BYPASS(WB_BYPASS)) u_rf (
    .clk(clk), .reset(reset), .wr_en(bus.i_wb_en), .wr_addr(bus.i_wb_addr), .wr_data(bus.i_wb_data),
    .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2)
  );
  // Output register: flush kills, accept captures, a free slot with nothing to take bubbles,
  // a stalled slot holds while tracking write-backs to its source registers.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus.o_valid            <= 1'b0;
      bus.o_decode_inst      <= NOP;
      bus.o_decode_pc        <= '0;
      bus.o_decode_pc_inc    <= '0;
      bus.o_decode_data_1    <= '0;
      bus.o_decode_data_2    <= '0;
      bus.o_decode_immediate <= '0;
      bus.o_decode_rd        <= '0;
      bus.o_decode_ctrl      <= '0;
    end else if (bus.i_flush) bus.o_valid <= 1'b0;
    else if (take) begin
      bus.o_valid            <= 1'b1;
      bus.o_decode_inst      <= bus.i_inst;
      bus.o_decode_pc        <= bus.i_pc;
      bus.o_decode_pc_inc    <= bus.i_pc_inc;
      bus.o_decode_data_1    <= rd1;
      bus.o_decode_data_2    <= rd2;
      bus.o_decode_immediate <= imm;
      bus.o_decode_rd        <= bus.i_inst[11:7];
      bus.o_decode_ctrl      <= ctrl;
    end else if (free) bus.o_valid <= 1'b0;
    else begin
      if (wb_hit && bus.i_wb_addr == hrs1) bus.o_decode_data_1 <= bus.i_wb_data;
      if (wb_hit && bus.i_wb_addr == hrs2) bus.o_decode_data_2 <= bus.i_wb_data;
    end
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed, table-driven and randomized checks of decode_pipe against a behavioural model
module tb_decode_pipe;
  import klp32_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  decode_pipe_if #(.XLEN(32)) b();
  decode_pipe_if #(.XLEN(32)) e();
  decode_pipe #(.XLEN(32), .NUM_REGS(32), .WB_BYPASS(1)) dut (.clk(clk), .reset(reset), .bus(b.slave));
  decode_pipe #(.XLEN(32), .NUM_REGS(16), .WB_BYPASS(1)) dut_e (.clk(clk), .reset(reset), .bus(e.slave));
  assign e.i_valid   = b.i_valid;
  assign e.i_inst    = b.i_inst;
  assign e.i_pc      = b.i_pc;
  assign e.i_pc_inc  = b.i_pc_inc;
  assign e.i_wb_en   = b.i_wb_en;
  assign e.i_wb_addr = b.i_wb_addr;
  assign e.i_wb_data = b.i_wb_data;
  assign e.i_flush   = b.i_flush;
  assign e.i_ready   = b.i_ready;
  int tests = 0;
  int fails = 0;
  logic rdy_seen;
  logic mv;
  logic [31:0] mi, mpc, mpi, m1, m2, mim;
  logic [4:0] mrd;
  logic [31:0] rf [32];
  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm;
    imm_sel_e    isel;
    alu_sel_e    asel;
    wb_sel_e     wsel;
    logic        wr, mrw, ld, ill, ill16;
  } vec_t;
  vec_t tbl [10];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic u1(input logic [6:0] o);
    case (o)
      7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  function automatic logic u2(input logic [6:0] o);
    return o == 7'b1100011 || o == 7'b0100011 || o == 7'b0110011;
  endfunction
  function automatic logic [31:0] ref_imm(input logic [31:0] x);
    case (x[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: return {{20{x[31]}}, x[31:20]};
      7'b0100011: return {{20{x[31]}}, x[31:25], x[11:7]};
      7'b1100011: return {{20{x[31]}}, x[7], x[30:25], x[11:8], 1'b0};
      7'b0110111, 7'b0010111: return {x[31:12], 12'h000};
      7'b1101111: return {{12{x[31]}}, x[19:12], x[20], x[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction
  function automatic logic [31:0] ref_read(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (b.i_wb_en && b.i_wb_addr == r) return b.i_wb_data;
    return rf[r];
  endfunction
  function automatic logic [31:0] rnd_inst();
    logic [4:0] d, s1, s2;
    logic [11:0] im;
    d = 5'($urandom_range(0, 7));
    s1 = 5'($urandom_range(0, 7));
    s2 = 5'($urandom_range(0, 7));
    im = 12'($urandom);
    case ($urandom_range(0, 4))
      0: return {7'h00, s2, s1, 3'b000, d, 7'b0110011};
      1: return {im, s1, 3'b010, d, 7'b0000011};
      2: return {im, s1, 3'b000, d, 7'b0010011};
      3: return {im[11:5], s2, s1, 3'b010, im[4:0], 7'b0100011};
      default: return {im, s2, s1[2:0], d, 7'b0110111};
    endcase
  endfunction
  task automatic cyc();
    logic fr, hz, ok;
    #1;
    fr = !mv || b.i_ready;
    hz = mv && mi[6:0] == 7'b0000011 && mrd != 5'd0 &&
         ((u1(b.i_inst[6:0]) && b.i_inst[19:15] == mrd) || (u2(b.i_inst[6:0]) && b.i_inst[24:20] == mrd));
    ok = fr && !hz && !b.i_flush;
    chk("o_ready", b.o_ready, ok);
    rdy_seen = b.o_ready;
    if (b.i_flush) mv = 1'b0;
    else if (b.i_valid && ok) begin
      mv = 1'b1;
      mi = b.i_inst;
      mpc = b.i_pc;
      mpi = b.i_pc_inc;
      m1 = ref_read(b.i_inst[19:15]);
      m2 = ref_read(b.i_inst[24:20]);
      mim = ref_imm(b.i_inst);
      mrd = b.i_inst[11:7];
    end else if (fr) mv = 1'b0;
    else begin
      if (b.i_wb_en && b.i_wb_addr != 5'd0 && b.i_wb_addr == mi[19:15]) m1 = b.i_wb_data;
      if (b.i_wb_en && b.i_wb_addr != 5'd0 && b.i_wb_addr == mi[24:20]) m2 = b.i_wb_data;
    end
    if (b.i_wb_en && b.i_wb_addr != 5'd0) rf[b.i_wb_addr] = b.i_wb_data;
    @(posedge clk);
    #1;
    chk("o_valid", b.o_valid, mv);
    chk("inst", b.o_decode_inst, mi);
    chk("pc", b.o_decode_pc, mpc);
    chk("pc_inc", b.o_decode_pc_inc, mpi);
    chk("data_1", b.o_decode_data_1, m1);
    chk("data_2", b.o_decode_data_2, m2);
    chk("imm", b.o_decode_immediate, mim);
    chk("rd", b.o_decode_rd, mrd);
  endtask
  task automatic present(input logic [31:0] inst);
    b.i_valid = 1'b1;
    b.i_inst = inst;
    b.i_pc = $urandom & 32'hFFFF_FFFC;
    b.i_pc_inc = b.i_pc + 32'd4;
  endtask
  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    b.i_wb_en = en;
    b.i_wb_addr = a;
    b.i_wb_data = d;
  endtask
  initial begin
    tbl[0] = '{32'hFE000EE3, 32'hFFFFFFFC, IMM_B, ALU_ADD, WB_ALU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'h01100093, 32'h00000011, IMM_I, ALU_ADD, WB_ALU, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{32'h01188833, 32'h00000000, IMM_NONE, ALU_ADD, WB_ALU, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{32'h40F50533, 32'h00000000, IMM_NONE, ALU_SUB, WB_ALU, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{32'h123452B7, 32'h12345000, IMM_U, ALU_PASS_B, WB_ALU, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{32'hFE512C23, 32'hFFFFFFF8, IMM_S, ALU_ADD, WB_ALU, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{32'h001000EF, 32'h00000800, IMM_J, ALU_ADD, WB_PC4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{32'h0000A283, 32'h00000000, IMM_I, ALU_ADD, WB_MEM, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{32'h0000007F, 32'h00000000, IMM_NONE, ALU_ADD, WB_ALU, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9] = '{32'h40525193, 32'h00000405, IMM_I, ALU_SRA, WB_ALU, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    b.i_valid = 1'b0; b.i_inst = 32'h0; b.i_pc = 32'h0; b.i_pc_inc = 32'h0;
    b.i_flush = 1'b0; b.i_ready = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    mv = 1'b0; mi = NOP; mpc = 0; mpi = 0; m1 = 0; m2 = 0; mim = 0; mrd = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", b.o_valid, 1'b0);
    chk("rst_ready", b.o_ready, 1'b1);
    chk("rst_inst", b.o_decode_inst, 32'h00000013);
    chk("rst_data_1", b.o_decode_data_1, 32'h0);
    chk("rst_data_2", b.o_decode_data_2, 32'h0);
    chk("rst_imm", b.o_decode_immediate, 32'h0);
    chk("rst_ctrl", b.o_decode_ctrl, '0);
    reset = 1'b1;
    b.i_ready = 1'b1;
    wb(1'b1, 5'd10, 32'd5);
    cyc();
    present(32'h40F50533);
    wb(1'b1, 5'd15, 32'd4);
    cyc();
    chk("byp_data_1", b.o_decode_data_1, 32'd5);
    chk("byp_data_2", b.o_decode_data_2, 32'd4);
    chk("byp_alu", b.o_decode_ctrl.alu_sel, ALU_SUB);
    present(32'h00A7B833);
    wb(1'b0, 5'd0, 32'h0);
    cyc();
    chk("bp_start_d1", b.o_decode_data_1, 32'd4);
    b.i_valid = 1'b0;
    b.i_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      wb(c == 1, 5'd15, 32'd9);
      cyc();
      chk("bp_ready", rdy_seen, 1'b0);
      chk("bp_inst", b.o_decode_inst, 32'h00A7B833);
      chk("bp_d1", b.o_decode_data_1, c == 0 ? 32'd4 : 32'd9);
    end
    wb(1'b0, 5'd0, 32'h0);
    b.i_ready = 1'b1;
    present(32'h0000A283);
    cyc();
    present(32'h00528333);
    cyc();
    chk("lu_stall_ready", rdy_seen, 1'b0);
    chk("lu_bubble", b.o_valid, 1'b0);
    cyc();
    chk("lu_accept_ready", rdy_seen, 1'b1);
    chk("lu_accept_inst", b.o_decode_inst, 32'h00528333);
    chk("lu_accept_valid", b.o_valid, 1'b1);
    present(32'h01100093);
    b.i_flush = 1'b1;
    wb(1'b1, 5'd7, 32'h77);
    cyc();
    chk("fl_valid", b.o_valid, 1'b0);
    chk("fl_inst_dropped", b.o_decode_inst, 32'h00528333);
    b.i_flush = 1'b0;
    present(32'h01100093);
    wb(1'b1, 5'd0, 32'hFFFFFFFF);
    cyc();
    chk("x0_d1", b.o_decode_data_1, 32'h0);
    present(32'h00038433);
    wb(1'b0, 5'd0, 32'h0);
    cyc();
    chk("fl_wb_commit", b.o_decode_data_1, 32'h77);
    chk("x0_d2", b.o_decode_data_2, 32'h0);
    for (int k = 0; k < 10; k++) begin
      present(tbl[k].inst);
      cyc();
      chk($sformatf("tbl%0d_imm", k), b.o_decode_immediate, tbl[k].imm);
      chk($sformatf("tbl%0d_isel", k), b.o_decode_ctrl.imm_sel, tbl[k].isel);
      chk($sformatf("tbl%0d_asel", k), b.o_decode_ctrl.alu_sel, tbl[k].asel);
      chk($sformatf("tbl%0d_wsel", k), b.o_decode_ctrl.wb_sel, tbl[k].wsel);
      chk($sformatf("tbl%0d_wr", k), b.o_decode_ctrl.reg_wr_en, tbl[k].wr);
      chk($sformatf("tbl%0d_mrw", k), b.o_decode_ctrl.mem_rw, tbl[k].mrw);
      chk($sformatf("tbl%0d_ld", k), b.o_decode_ctrl.is_load, tbl[k].ld);
      chk($sformatf("tbl%0d_ill", k), b.o_decode_ctrl.illegal, tbl[k].ill);
      chk($sformatf("tbl%0d_e_valid", k), e.o_valid, 1'b1);
      chk($sformatf("tbl%0d_e_ill", k), e.o_decode_ctrl.illegal, tbl[k].ill16);
      chk($sformatf("tbl%0d_e_wr", k), e.o_decode_ctrl.reg_wr_en, tbl[k].wr & !tbl[k].ill16);
      b.i_valid = 1'b0;
      cyc();
    end
    for (int n = 0; n < 400; n++) begin
      present(rnd_inst());
      b.i_valid = $urandom_range(0, 3) != 0;
      b.i_ready = $urandom_range(0, 3) != 0;
      b.i_flush = $urandom_range(0, 15) == 0;
      wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
